// File: rtl/mcb_ini_cmd.sv
// rtl/mcb_ini_cmd.sv - SDRAM init command issuer: power-up wait, refresh quota, mode load, pin drive
// Optional protocol checker enabled by defining MCB_INI_CMD_CHK_EN (drives cmd_err).
module mcb_ini_cmd #(
  parameter int          INI_WAIT_CYC = 20000,
  parameter int          REF_NUM      = 8,
  parameter int          I_CMD_CNT_W  = 4,
  parameter logic [12:0] MR_VAL       = 13'h032
) (
  input  logic                   mcb_clk,
  input  logic                   mcb_rst_n,
  input  logic                   i_cmd_cnt_sclr,
  input  logic                   i_prea,
  input  logic                   i_ref,
  input  logic                   i_lmr,
  input  logic                   i_ready,
  output logic                   i_ini_w_done,
  output logic                   i_ref_n_done,
  output logic [I_CMD_CNT_W-1:0] i_cmd_cnt,
  output logic                   sd_cke,
  output logic                   sd_cs_n,
  output logic                   sd_ras_n,
  output logic                   sd_cas_n,
  output logic                   sd_we_n,
  output logic [12:0]            sd_addr,
  output logic [1:0]             sd_ba,
  output logic                   sd_init_done,
  output logic                   cmd_err
);

  // Wait counter only needs to reach INI_WAIT_CYC-1, then it parks there.
  localparam int                WAIT_W    = (INI_WAIT_CYC > 1) ? $clog2(INI_WAIT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INI_WAIT_CYC - 1);
  localparam logic [3:0]        REF_LAST  = 4'(REF_NUM);
  localparam logic [4:0]        REF_GOAL  = 5'(REF_NUM);
  localparam logic [12:0]       A10_ONLY  = 13'h0400;

  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        ref_cnt;
  logic              cke_arm;

  // Once init is done the command path is frozen; only one request may win a cycle.
  logic prea_win;
  logic ref_win;
  logic lmr_win;

  assign prea_win = i_prea & ~sd_init_done;
  assign ref_win  = i_ref & ~i_prea & ~sd_init_done;
  assign lmr_win  = i_lmr & ~i_ref & ~i_prea & ~sd_init_done;

  // Include the in-flight refresh so the init FSM sees the quota in the same cycle.
  assign i_ref_n_done = ({1'b0, ref_cnt} + {4'b0000, i_ref}) >= REF_GOAL;

  // Power-up wait: free-running count from reset, done flag latches one edge after the last count.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      wait_cnt     <= '0;
      i_ini_w_done <= 1'b0;
    end else begin
      if (wait_cnt != WAIT_LAST) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt == WAIT_LAST) begin
        i_ini_w_done <= 1'b1;
      end
    end
  end

  // Command-interval counter: cleared by the FSM, saturates so long gaps never look short.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      i_cmd_cnt <= '0;
    end else if (i_cmd_cnt_sclr) begin
      i_cmd_cnt <= '0;
    end else if (i_cmd_cnt != {I_CMD_CNT_W{1'b1}}) begin
      i_cmd_cnt <= i_cmd_cnt + 1'b1;
    end
  end

  // Refresh quota counter: counts issued AUTO REFRESH commands, capped at REF_NUM.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      ref_cnt <= '0;
    end else if (ref_win && (ref_cnt != REF_LAST)) begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Clock enable rises on the second edge after reset release.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      cke_arm <= 1'b0;
      sd_cke  <= 1'b0;
    end else begin
      cke_arm <= 1'b1;
      sd_cke  <= cke_arm;
    end
  end

  // Registered command pins: one-cycle command per winning request, NOP otherwise.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      sd_cs_n  <= 1'b0;
      sd_ras_n <= 1'b1;
      sd_cas_n <= 1'b1;
      sd_we_n  <= 1'b1;
      sd_addr  <= '0;
      sd_ba    <= '0;
    end else begin
      sd_cs_n <= 1'b0;
      sd_ba   <= '0;
      if (prea_win) begin
        sd_ras_n <= 1'b0;
        sd_cas_n <= 1'b1;
        sd_we_n  <= 1'b0;
        sd_addr  <= A10_ONLY;
      end else if (ref_win) begin
        sd_ras_n <= 1'b0;
        sd_cas_n <= 1'b0;
        sd_we_n  <= 1'b1;
        sd_addr  <= '0;
      end else if (lmr_win) begin
        sd_ras_n <= 1'b0;
        sd_cas_n <= 1'b0;
        sd_we_n  <= 1'b0;
        sd_addr  <= MR_VAL;
      end else begin
        sd_ras_n <= 1'b1;
        sd_cas_n <= 1'b1;
        sd_we_n  <= 1'b1;
        sd_addr  <= '0;
      end
    end
  end

  // Init-complete flag: i_ready delayed one edge, sticky until reset.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      sd_init_done <= 1'b0;
    end else if (i_ready) begin
      sd_init_done <= 1'b1;
    end
  end

`ifdef MCB_INI_CMD_CHK_EN
  logic req_multi;
  logic req_any;
  logic err_now;

  assign req_multi = (i_prea & i_ref) | (i_prea & i_lmr) | (i_ref & i_lmr);
  assign req_any   = i_prea | i_ref | i_lmr;
  assign err_now   = req_multi | (req_any & ~i_ini_w_done) | (i_lmr & ~i_ref_n_done);

  // Sticky protocol error: conflicting requests, early requests, or mode load before refresh quota.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      cmd_err <= 1'b0;
    end else if (err_now) begin
      cmd_err <= 1'b1;
    end
  end
`else
  assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_mcb_ini_cmd.sv
// tb/tb_mcb_ini_cmd.sv - directed self-checking bench for mcb_ini_cmd
module tb_mcb_ini_cmd;

`ifdef MCB_INI_CMD_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam logic [3:0] P_NOP  = 4'b0111;
  localparam logic [3:0] P_PREA = 4'b0010;
  localparam logic [3:0] P_REF  = 4'b0001;
  localparam logic [3:0] P_LMR  = 4'b0000;

  logic        mcb_clk;
  logic        mcb_rst_n;
  logic        i_cmd_cnt_sclr;
  logic        i_prea;
  logic        i_ref;
  logic        i_lmr;
  logic        i_ready;
  logic        i_ini_w_done;
  logic        i_ref_n_done;
  logic [3:0]  i_cmd_cnt;
  logic        sd_cke;
  logic        sd_cs_n;
  logic        sd_ras_n;
  logic        sd_cas_n;
  logic        sd_we_n;
  logic [12:0] sd_addr;
  logic [1:0]  sd_ba;
  logic        sd_init_done;
  logic        cmd_err;

  int n_pass;
  int n_fail;
  int n_tot;

  mcb_ini_cmd #(
    .INI_WAIT_CYC(10),
    .REF_NUM     (2),
    .I_CMD_CNT_W (4),
    .MR_VAL      (13'h032)
  ) dut (
    .mcb_clk       (mcb_clk),
    .mcb_rst_n     (mcb_rst_n),
    .i_cmd_cnt_sclr(i_cmd_cnt_sclr),
    .i_prea        (i_prea),
    .i_ref         (i_ref),
    .i_lmr         (i_lmr),
    .i_ready       (i_ready),
    .i_ini_w_done  (i_ini_w_done),
    .i_ref_n_done  (i_ref_n_done),
    .i_cmd_cnt     (i_cmd_cnt),
    .sd_cke        (sd_cke),
    .sd_cs_n       (sd_cs_n),
    .sd_ras_n      (sd_ras_n),
    .sd_cas_n      (sd_cas_n),
    .sd_we_n       (sd_we_n),
    .sd_addr       (sd_addr),
    .sd_ba         (sd_ba),
    .sd_init_done  (sd_init_done),
    .cmd_err       (cmd_err)
  );

  initial mcb_clk = 1'b0;
  always #5 mcb_clk = ~mcb_clk;

  function automatic logic [3:0] pins();
    return {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};
  endfunction

  task automatic tick();
    @(posedge mcb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] exp_p, input logic [12:0] exp_a);
    chk({tag, "_pins"}, 32'(pins()), 32'(exp_p));
    chk({tag, "_addr"}, 32'(sd_addr), 32'(exp_a));
    chk({tag, "_ba"}, 32'(sd_ba), 32'd0);
  endtask

  initial begin
    n_pass = 0;
    n_fail = 0;
    n_tot  = 0;
    mcb_rst_n      = 1'b0;
    i_cmd_cnt_sclr = 1'b0;
    i_prea         = 1'b0;
    i_ref          = 1'b0;
    i_lmr          = 1'b0;
    i_ready        = 1'b0;

    // Reset state
    tick();
    tick();
    chk_pins("rst", P_NOP, 13'h000);
    chk("rst_wdone", 32'(i_ini_w_done), 32'd0);
    chk("rst_cmdcnt", 32'(i_cmd_cnt), 32'd0);
    chk("rst_cke", 32'(sd_cke), 32'd0);
    chk("rst_initdone", 32'(sd_init_done), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_refdone", 32'(i_ref_n_done), 32'd0);

    // Power-up wait and clock enable
    mcb_rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("wait_wdone_%0d", k), 32'(i_ini_w_done), (k >= 10) ? 32'd1 : 32'd0);
      chk($sformatf("wait_cke_%0d", k), 32'(sd_cke), (k >= 2) ? 32'd1 : 32'd0);
    end
    chk("wait_cmdcnt", 32'(i_cmd_cnt), 32'd10);

    // PRECHARGE ALL, then NOP
    i_prea = 1'b1;
    tick();
    i_prea = 1'b0;
    chk_pins("prea", P_PREA, 13'h400);
    tick();
    chk_pins("prea_nop", P_NOP, 13'h000);
    chk("prea_err", 32'(cmd_err), 32'd0);

    // Simultaneous PRECHARGE and REFRESH: precharge wins, refresh not counted
    i_prea = 1'b1;
    i_ref  = 1'b1;
    #1;
    chk("both_refdone_comb", 32'(i_ref_n_done), 32'd0);
    tick();
    i_prea = 1'b0;
    i_ref  = 1'b0;
    #1;
    chk_pins("both", P_PREA, 13'h400);
    chk("both_refdone_after", 32'(i_ref_n_done), 32'd0);
    chk("both_err", 32'(cmd_err), 32'(CHK));

    // Two AUTO REFRESH pulses against REF_NUM=2
    i_ref = 1'b1;
    #1;
    chk("ref1_refdone", 32'(i_ref_n_done), 32'd0);
    tick();
    chk_pins("ref1", P_REF, 13'h000);
    chk("ref2_refdone", 32'(i_ref_n_done), 32'd1);
    tick();
    i_ref = 1'b0;
    #1;
    chk_pins("ref2", P_REF, 13'h000);
    chk("ref_after_refdone", 32'(i_ref_n_done), 32'd1);
    tick();
    chk_pins("ref_nop", P_NOP, 13'h000);

    // LOAD MODE
    i_lmr = 1'b1;
    tick();
    i_lmr = 1'b0;
    chk_pins("lmr", P_LMR, 13'h032);
    chk("lmr_err", 32'(cmd_err), 32'(CHK));
    tick();
    chk_pins("lmr_nop", P_NOP, 13'h000);

    // Command-interval counter clear and saturation
    i_cmd_cnt_sclr = 1'b1;
    tick();
    i_cmd_cnt_sclr = 1'b0;
    chk("cnt_clr", 32'(i_cmd_cnt), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("cnt_%0d", k), 32'(i_cmd_cnt), (k > 15) ? 32'd15 : 32'(k));
    end

    // Init complete one edge after i_ready, sticky
    i_ready = 1'b1;
    #1;
    chk("ready_pre", 32'(sd_init_done), 32'd0);
    tick();
    i_ready = 1'b0;
    chk("ready_done", 32'(sd_init_done), 32'd1);
    tick();
    chk("ready_sticky", 32'(sd_init_done), 32'd1);

    // Requests ignored after init, interval counter still runs
    i_cmd_cnt_sclr = 1'b1;
    tick();
    i_cmd_cnt_sclr = 1'b0;
    i_prea = 1'b1;
    tick();
    i_prea = 1'b0;
    chk_pins("post_prea", P_NOP, 13'h000);
    chk("post_cmdcnt", 32'(i_cmd_cnt), 32'd1);
    i_lmr = 1'b1;
    tick();
    i_lmr = 1'b0;
    chk_pins("post_lmr", P_NOP, 13'h000);

    // Reset is synchronous: outputs hold until the edge
    mcb_rst_n = 1'b0;
    #1;
    chk("arst_initdone", 32'(sd_init_done), 32'd1);
    chk("arst_cke", 32'(sd_cke), 32'd1);
    chk("arst_wdone", 32'(i_ini_w_done), 32'd1);
    tick();
    chk("srst_initdone", 32'(sd_init_done), 32'd0);
    chk("srst_cke", 32'(sd_cke), 32'd0);
    chk("srst_err", 32'(cmd_err), 32'd0);

    // Wait restarts from 0
    mcb_rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rewait_wdone_%0d", k), 32'(i_ini_w_done), (k >= 10) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of refresh recovery
    i_ref = 1'b1;
    tick();
    tick();
    i_ref = 1'b0;
    mcb_rst_n = 1'b0;
    #1;
    chk_pins("trfc_hold", P_REF, 13'h000);
    chk("trfc_refdone", 32'(i_ref_n_done), 32'd1);
    tick();
    chk_pins("trfc_rst", P_NOP, 13'h000);
    chk("trfc_cmdcnt", 32'(i_cmd_cnt), 32'd0);
    chk("trfc_wdone", 32'(i_ini_w_done), 32'd0);
    chk("trfc_refcnt", 32'(i_ref_n_done), 32'd0);
    chk("trfc_cke", 32'(sd_cke), 32'd0);
    mcb_rst_n = 1'b1;
    tick();
    chk("trfc_cmdcnt_restart", 32'(i_cmd_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
